// File: rtl/ram_cmd_pkg.sv
// ============================================================================
// Module  : ram_cmd_pkg
// Brief   : Opcode constants and FSM state encoding shared with the RAM side.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ram_cmd_pkg;

    localparam logic [1:0] c_OP_WRITE_ADD  = 2'b00;
    localparam logic [1:0] c_OP_WRITE_DATA = 2'b01;
    localparam logic [1:0] c_OP_READ_ADD   = 2'b10;
    localparam logic [1:0] c_OP_READ_DATA  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RD_WAIT = 3'd5,
        ST_RESP    = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/ram_cmd_master.sv
// ============================================================================
// Module  : ram_cmd_master
// Brief   : Turns host read/write requests into RAM command words and returns
//           a one-cycle response, with a bounded wait for read data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ram_cmd_master
    import ram_cmd_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [9:0] din,
    output logic       rx_valid,
    input  logic [7:0] dout,
    input  logic       tx_valid,
    output logic       busy
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    state_e             r_state_q, w_state_d;
    logic               r_write_q, w_write_d;
    logic [7:0]         r_addr_q,  w_addr_d;
    logic [7:0]         r_wdata_q, w_wdata_d;
    logic [7:0]         r_rdata_q, w_rdata_d;
    logic               r_err_q,   w_err_d;
    logic [c_CNT_W-1:0] r_cnt_q,   w_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_write_q <= 1'b0;
            r_addr_q  <= 8'h00;
            r_wdata_q <= 8'h00;
            r_rdata_q <= 8'h00;
            r_err_q   <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_write_q <= w_write_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_rdata_q <= w_rdata_d;
            r_err_q   <= w_err_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_write_d = r_write_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_rdata_d = r_rdata_q;
        w_err_d   = r_err_q;
        w_cnt_d   = '0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        din       = 10'h000;
        rx_valid  = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_write_d = req_write;
                    w_addr_d  = req_addr;
                    w_wdata_d = req_wdata;
                    w_err_d   = 1'b0;
                    w_state_d = req_write ? ST_WR_ADDR : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR: begin
                din       = {c_OP_WRITE_ADD, r_addr_q};
                rx_valid  = 1'b1;
                w_state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                din       = {c_OP_WRITE_DATA, r_wdata_q};
                rx_valid  = 1'b1;
                w_state_d = ST_RESP;
            end
            ST_RD_ADDR: begin
                din       = {c_OP_READ_ADD, r_addr_q};
                rx_valid  = 1'b1;
                w_state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                din       = {c_OP_READ_DATA, 8'h00};
                rx_valid  = 1'b1;
                w_state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // The counter covers TIMEOUT wait cycles, so it never reaches its wrap point.
                if (tx_valid) begin
                    w_rdata_d = dout;
                    w_err_d   = 1'b0;
                    w_state_d = ST_RESP;
                end else if (r_cnt_q == c_CNT_LAST) begin
                    w_rdata_d = 8'h00;
                    w_err_d   = 1'b1;
                    w_state_d = ST_RESP;
                end else begin
                    w_cnt_d   = r_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = r_err_q & ~r_write_q;
                w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    assign rsp_rdata = r_rdata_q;
    assign busy      = (r_state_q != ST_IDLE);

endmodule

`default_nettype wire
